// File: rtl/i281_dbg_pkg.sv
// Shared encodings and default widths for the i281 run/step/breakpoint debug logic.
package i281_dbg_pkg;

  localparam int PC_W_DEF  = 6;
  localparam int CYC_W_DEF = 16;
  localparam int INS_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_STEP  = 2'b10,
    ST_BREAK = 2'b11
  } run_state_e;

endpackage

// File: rtl/i281_sat_counter.sv
// Saturating up-counter; a synchronous clear takes priority over the increment.
module i281_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         en_i,
  input  logic         clr_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && !(&count_q)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/i281_run_controller.sv
// Run/step/breakpoint sequencer for the i281 CPU; gates the global run enable so the
// core only ever parks at an instruction boundary (fetch cycle), and counts activity.
module i281_run_controller
  import i281_dbg_pkg::*;
#(
  parameter int PC_W  = PC_W_DEF,
  parameter int CYC_W = CYC_W_DEF,
  parameter int INS_W = INS_W_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             run_req,
  input  logic             step_req,
  input  logic             halt_req,
  input  logic             bp_enable,
  input  logic [PC_W-1:0]  bp_addr,
  input  logic [PC_W-1:0]  pc,
  input  logic             fetch,
  input  logic             clear_counts,
  output logic             run_en,
  output logic [1:0]       state,
  output logic             at_bp,
  output logic [CYC_W-1:0] cycle_count,
  output logic [INS_W-1:0] instr_count
);

  run_state_e state_q, state_d;
  logic       step_req_q;
  logic       run_req_q;
  logic       bp_skip_q, bp_skip_d;
  logic       step_started_q, step_started_d;

  logic step_edge;
  logic run_edge;
  logic stop_bp;
  logic end_req;

  assign step_edge = step_req & ~step_req_q;
  assign run_edge  = run_req & ~run_req_q;
  // bp_skip lets a resume from the breakpoint address execute that instruction once
  assign stop_bp   = bp_enable & (pc == bp_addr) & ~bp_skip_q;
  assign end_req   = halt_req | ~run_req | stop_bp;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      step_req_q     <= 1'b0;
      run_req_q      <= 1'b0;
      bp_skip_q      <= 1'b0;
      step_started_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      step_req_q     <= step_req;
      run_req_q      <= run_req;
      bp_skip_q      <= bp_skip_d;
      step_started_q <= step_started_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    bp_skip_d      = bp_skip_q;
    step_started_d = step_started_q;
    if (run_en && fetch) begin
      bp_skip_d = 1'b0;
    end
    case (state_q)
      ST_IDLE: begin
        if (!halt_req) begin
          if (run_req) begin
            state_d   = ST_RUN;
            bp_skip_d = 1'b1;
          end else if (step_edge) begin
            state_d   = ST_STEP;
            bp_skip_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (fetch) begin
          if (stop_bp) begin
            state_d = ST_BREAK;
          end else if (halt_req || !run_req) begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_STEP: begin
        // First STEP cycle executes the pending fetch; the next fetch ends the step
        if (!step_started_q) begin
          step_started_d = 1'b1;
        end else if (fetch) begin
          step_started_d = 1'b0;
          state_d        = stop_bp ? ST_BREAK : ST_IDLE;
        end
      end
      ST_BREAK: begin
        if (!halt_req) begin
          if (step_edge) begin
            state_d   = ST_STEP;
            bp_skip_d = 1'b1;
          end else if (run_edge) begin
            state_d   = ST_RUN;
            bp_skip_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    run_en = 1'b0;
    at_bp  = 1'b0;
    case (state_q)
      ST_IDLE:  run_en = 1'b0;
      ST_RUN:   run_en = ~(fetch & end_req);
      ST_STEP:  run_en = ~(step_started_q & fetch);
      ST_BREAK: at_bp  = 1'b1;
      default:  run_en = 1'b0;
    endcase
  end

  assign state = state_q;

  i281_sat_counter #(.W(CYC_W)) u_cycle_cnt (
    .clk_i   (clock),
    .rst_ni  (reset),
    .en_i    (run_en),
    .clr_i   (clear_counts),
    .count_o (cycle_count)
  );

  i281_sat_counter #(.W(INS_W)) u_instr_cnt (
    .clk_i   (clock),
    .rst_ni  (reset),
    .en_i    (run_en & fetch),
    .clr_i   (clear_counts),
    .count_o (instr_count)
  );

endmodule

// File: tb/tb_i281_run_controller.sv
// Directed bench for i281_run_controller driving a simple 3-cycle-per-instruction CPU model.
module tb_i281_run_controller;

  logic        clock = 1'b0;
  logic        reset;
  logic        run_req, step_req, halt_req, bp_enable, clear_counts;
  logic [5:0]  bp_addr;
  logic [5:0]  pc;
  logic        fetch;
  logic        run_en;
  logic [1:0]  state;
  logic        at_bp;
  logic [15:0] cycle_count, instr_count;

  logic        run_en_s;
  logic [1:0]  state_s;
  logic        at_bp_s;
  logic [3:0]  cyc_s, ins_s;

  logic [1:0]  ph_q;
  logic [5:0]  pc_q;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  i281_run_controller dut (
    .clock(clock), .reset(reset), .run_req(run_req), .step_req(step_req),
    .halt_req(halt_req), .bp_enable(bp_enable), .bp_addr(bp_addr), .pc(pc),
    .fetch(fetch), .clear_counts(clear_counts), .run_en(run_en), .state(state),
    .at_bp(at_bp), .cycle_count(cycle_count), .instr_count(instr_count)
  );

  i281_run_controller #(.PC_W(6), .CYC_W(4), .INS_W(4)) dut_s (
    .clock(clock), .reset(reset), .run_req(run_req), .step_req(step_req),
    .halt_req(halt_req), .bp_enable(bp_enable), .bp_addr(bp_addr), .pc(pc),
    .fetch(fetch), .clear_counts(clear_counts), .run_en(run_en_s), .state(state_s),
    .at_bp(at_bp_s), .cycle_count(cyc_s), .instr_count(ins_s)
  );

  // CPU stand-in: phase 0 is fetch, pc advances when the fetch executes
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ph_q <= 2'd0;
      pc_q <= 6'd0;
    end else if (run_en) begin
      ph_q <= (ph_q == 2'd2) ? 2'd0 : ph_q + 2'd1;
      if (ph_q == 2'd0) pc_q <= pc_q + 6'd1;
    end
  end

  assign fetch = (ph_q == 2'd0);
  assign pc    = pc_q;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_state(input logic [1:0] exp, input int budget, input string tag);
    for (int i = 0; i < budget; i++) begin
      if (state === exp) break;
      tick();
    end
    chk(tag, {30'd0, state}, {30'd0, exp});
  endtask

  initial begin
    reset = 1'b0; run_req = 1'b1; step_req = 1'b0; halt_req = 1'b0;
    bp_enable = 1'b0; bp_addr = 6'd5; clear_counts = 1'b0;
    repeat (3) tick();
    chk("rst_run_en", {31'd0, run_en}, 32'd0);
    chk("rst_state", {30'd0, state}, 32'd0);
    chk("rst_at_bp", {31'd0, at_bp}, 32'd0);
    chk("rst_cycles", {16'd0, cycle_count}, 32'd0);
    chk("rst_instrs", {16'd0, instr_count}, 32'd0);

    reset = 1'b1;
    tick();
    chk("run_after_reset", {30'd0, state}, 32'd1);
    chk("run_en_after_reset", {31'd0, run_en}, 32'd1);
    chk("cycles_after_reset", {16'd0, cycle_count}, 32'd0);
    tick();
    chk("cycles_1", {16'd0, cycle_count}, 32'd1);
    chk("instrs_1", {16'd0, instr_count}, 32'd1);

    run_req = 1'b0;
    tick();
    chk("drop_run_midinstr_en", {31'd0, run_en}, 32'd1);
    chk("drop_run_midinstr_state", {30'd0, state}, 32'd1);
    tick();
    chk("park_at_fetch_en", {31'd0, run_en}, 32'd0);
    chk("park_at_fetch_state", {30'd0, state}, 32'd1);
    tick();
    chk("idle_after_drop", {30'd0, state}, 32'd0);
    chk("cycles_after_drop", {16'd0, cycle_count}, 32'd3);
    chk("instrs_after_drop", {16'd0, instr_count}, 32'd1);

    bp_enable = 1'b1;
    run_req   = 1'b1;
    wait_state(2'b11, 40, "bp_reached");
    chk("bp_run_en", {31'd0, run_en}, 32'd0);
    chk("bp_at_bp", {31'd0, at_bp}, 32'd1);
    chk("bp_instrs", {16'd0, instr_count}, 32'd5);
    chk("bp_cycles", {16'd0, cycle_count}, 32'd15);
    chk("bp_pc", {26'd0, pc}, 32'd5);

    run_req = 1'b0;
    tick();
    chk("break_holds", {30'd0, state}, 32'd3);
    step_req = 1'b1;
    tick();
    chk("step_entered", {30'd0, state}, 32'd2);
    chk("step_first_en", {31'd0, run_en}, 32'd1);
    step_req = 1'b0;
    wait_state(2'b00, 20, "step_done");
    chk("step_instrs", {16'd0, instr_count}, 32'd6);
    chk("step_cycles", {16'd0, cycle_count}, 32'd18);
    chk("step_at_bp", {31'd0, at_bp}, 32'd0);

    step_req = 1'b1;
    repeat (20) tick();
    chk("held_step_state", {30'd0, state}, 32'd0);
    chk("held_step_instrs", {16'd0, instr_count}, 32'd7);
    chk("held_step_cycles", {16'd0, cycle_count}, 32'd21);
    step_req = 1'b0;

    halt_req = 1'b1;
    run_req  = 1'b1;
    repeat (3) tick();
    chk("halt_blocks_state", {30'd0, state}, 32'd0);
    chk("halt_blocks_cycles", {16'd0, cycle_count}, 32'd21);
    halt_req = 1'b0;
    tick();
    chk("run_after_halt", {30'd0, state}, 32'd1);
    tick();
    halt_req = 1'b1;
    tick();
    chk("halt_midinstr_en", {31'd0, run_en}, 32'd1);
    tick();
    chk("halt_park_en", {31'd0, run_en}, 32'd0);
    chk("halt_park_state", {30'd0, state}, 32'd1);
    tick();
    chk("halt_idle", {30'd0, state}, 32'd0);
    chk("halt_cycles", {16'd0, cycle_count}, 32'd24);
    chk("halt_instrs", {16'd0, instr_count}, 32'd8);
    chk("sat_small_cycles", {28'd0, cyc_s}, 32'd15);
    chk("small_instrs", {28'd0, ins_s}, 32'd8);

    halt_req     = 1'b0;
    clear_counts = 1'b1;
    tick();
    chk("clear_state", {30'd0, state}, 32'd1);
    chk("clear_cycles", {16'd0, cycle_count}, 32'd0);
    chk("clear_small_cycles", {28'd0, cyc_s}, 32'd0);
    tick();
    chk("clear_wins_cycles", {16'd0, cycle_count}, 32'd0);
    chk("clear_wins_instrs", {16'd0, instr_count}, 32'd0);
    clear_counts = 1'b0;
    repeat (60) tick();
    chk("run60_cycles", {16'd0, cycle_count}, 32'd60);
    chk("run60_instrs", {16'd0, instr_count}, 32'd20);
    chk("sat_small_cycles2", {28'd0, cyc_s}, 32'd15);
    chk("sat_small_instrs", {28'd0, ins_s}, 32'd15);

    run_req = 1'b0;
    wait_state(2'b00, 10, "final_idle");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
